// File: rtl/pe_ejection_sink.sv
// ---------------------------------------------------------------------------
// pe_ejection_sink
//
// Per-PE packet sink on a router's local ejection port. Every valid flit is
// consumed in the cycle it is presented, and a one-cycle credit is returned on
// its VC. Wormhole framing is tracked per VC. Each completed packet's latency
// is computed from the injection timestamp in its head flit. Statistics are
// accumulated once warm-up is over. On request, a 64-cycle restoring divider
// produces the average latency.
//
// Optional feature macro: PE_SINK_MAX_LAT_EN
//   Defined     : a max-latency register is built and drives max_latency.
//   Not defined : no register is built; max_latency is tied to 0.
//
// Ports
//   clk                  in   clock
//   full_rs              in   asynchronous active-low reset
//   flit_valid           in   flit present this cycle
//   flit_in              in   flit data; head flits carry ts in [ts_width-1:0]
//   flit_type            in   00 body, 01 head, 10 tail, 11 head+tail
//   flit_vc              in   VC of the flit
//   credit_out           out  one-cycle credit pulse per consumed flit, bit = VC
//   stats_clr            in   synchronous clear of statistics and protocol_err
//   report_req           in   start an average-latency report
//   report_busy          out  report in progress (LATCH through DONE)
//   report_valid         out  one-cycle pulse, result outputs valid
//   no_packet_recieve    out  packet count snapshot
//   averge_time_of_flies out  average latency snapshot, cycles
//   max_latency          out  largest counted latency (0 if feature disabled)
//   protocol_err         out  sticky framing-error flag
// ---------------------------------------------------------------------------
module pe_ejection_sink #(
    parameter int no_vc        = 4,
    parameter int phit_size    = 32,
    parameter int ts_width     = 24,
    parameter int warm_up_time = 2000,
    localparam int vc_bits     = (no_vc > 1) ? $clog2(no_vc) : 1
) (
    input  logic                 clk,
    input  logic                 full_rs,
    input  logic                 flit_valid,
    input  logic [phit_size-1:0] flit_in,
    input  logic [1:0]           flit_type,
    input  logic [vc_bits-1:0]   flit_vc,
    output logic [no_vc-1:0]     credit_out,
    input  logic                 stats_clr,
    input  logic                 report_req,
    output logic                 report_busy,
    output logic                 report_valid,
    output logic [31:0]          no_packet_recieve,
    output logic [31:0]          averge_time_of_flies,
    output logic [ts_width-1:0]  max_latency,
    output logic                 protocol_err
);

    typedef enum logic [1:0] {RPT_IDLE, RPT_LATCH, RPT_DIV, RPT_DONE} rpt_state_t;

    logic [31:0]          cycle_cnt;
    logic [no_vc-1:0]     vc_in_pkt;
    logic [ts_width-1:0]  vc_ts [no_vc];
    logic [31:0]          pkt_cnt;
    logic [63:0]          lat_sum;

    // Only the timestamp field of the flit is used by the sink.
    logic unused_flit_bits;
    assign unused_flit_bits = ^flit_in[phit_size-1:ts_width];

    // ---------------- flit classification ----------------
    logic                is_head, is_tail, cur_in_pkt;
    logic                complete, err_evt, count_en;
    logic [ts_width-1:0] flit_ts, ts_used, latency;

    assign is_head    = flit_type[0];
    assign is_tail    = flit_type[1];
    assign cur_in_pkt = vc_in_pkt[flit_vc];
    assign flit_ts    = flit_in[ts_width-1:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        complete = 1'b0;
        err_evt  = 1'b0;
        ts_used  = vc_ts[flit_vc];
        if (flit_valid) begin
            // Head while a packet is open, or body/tail with none open.
            err_evt = (is_head && cur_in_pkt) || (!is_head && !cur_in_pkt);
            if (is_head && is_tail) begin
                complete = 1'b1;
                ts_used  = flit_ts;
            end else if (is_tail && cur_in_pkt) begin
                complete = 1'b1;
            end
        end
    end

    // Modular subtraction absorbs timestamp wrap-around.
    assign latency  = cycle_cnt[ts_width-1:0] - ts_used;
    assign count_en = complete && (cycle_cnt >= 32'(warm_up_time));

    // ---------------- cycle counter, credits, per-VC state ----------------
    always_ff @(posedge clk or negedge full_rs) begin
        if (!full_rs) begin
            cycle_cnt  <= '0;
            credit_out <= '0;
            vc_in_pkt  <= '0;
            // NOTE: the per-VC timestamp store is a handful of flops, not a
            // RAM, so it is reset along with everything else.
            for (int i = 0; i < no_vc; i++) vc_ts[i] <= '0;
        end else begin
            // NOTE: sequential state is only ever assigned with <=, so every
            // flop samples the values from before this edge.
            cycle_cnt  <= cycle_cnt + 32'd1;
            credit_out <= '0;
            if (flit_valid) begin
                credit_out[flit_vc] <= 1'b1;
                if (is_head && !is_tail) begin
                    // Also covers a restart after an unexpected head.
                    vc_in_pkt[flit_vc] <= 1'b1;
                    vc_ts[flit_vc]     <= flit_ts;
                end else if (is_tail) begin
                    vc_in_pkt[flit_vc] <= 1'b0;
                end
            end
        end
    end

    // ---------------- statistics ----------------
    logic [64:0] sum_ext;
    assign sum_ext = {1'b0, lat_sum} + 65'(latency);

    always_ff @(posedge clk or negedge full_rs) begin
        if (!full_rs) begin
            pkt_cnt      <= '0;
            lat_sum      <= '0;
            protocol_err <= 1'b0;
        end else if (stats_clr) begin
            // Clear wins over a packet completing in the same cycle.
            pkt_cnt      <= '0;
            lat_sum      <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (err_evt) protocol_err <= 1'b1;
            if (count_en) begin
                if (pkt_cnt != 32'hFFFF_FFFF) pkt_cnt <= pkt_cnt + 32'd1;
                lat_sum <= sum_ext[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum_ext[63:0];
            end
        end
    end

`ifdef PE_SINK_MAX_LAT_EN
    logic [ts_width-1:0] max_lat_q;
    always_ff @(posedge clk or negedge full_rs) begin
        if (!full_rs)                          max_lat_q <= '0;
        else if (stats_clr)                    max_lat_q <= '0;
        else if (count_en && latency > max_lat_q) max_lat_q <= latency;
    end
    assign max_latency = max_lat_q;
`else
    assign max_latency = '0;
`endif

    // ---------------- report FSM ----------------
    rpt_state_t state, state_next;
    logic [63:0] div_q;
    logic [31:0] div_rem, div_d;
    logic [5:0]  div_iter;

    always_ff @(posedge clk or negedge full_rs) begin
        if (!full_rs) state <= RPT_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RPT_IDLE:  if (report_req) state_next = RPT_LATCH;
            RPT_LATCH: state_next = (pkt_cnt == '0) ? RPT_DONE : RPT_DIV;
            RPT_DIV:   if (div_iter == 6'd63) state_next = RPT_DONE;
            RPT_DONE:  state_next = RPT_IDLE;
            default:   state_next = RPT_IDLE;
        endcase
    end

    always_comb begin
        report_busy  = (state != RPT_IDLE);
        report_valid = (state == RPT_DONE);
    end

    // One restoring-division step: the dividend shifts out of div_q MSB-first
    // while quotient bits shift in at the bottom.
    logic [32:0] rem_shift, rem_next;
    logic        rem_ge;
    logic [63:0] q_next;

    assign rem_shift = {div_rem, div_q[63]};
    assign rem_ge    = (rem_shift >= {1'b0, div_d});
    assign rem_next  = rem_ge ? (rem_shift - {1'b0, div_d}) : rem_shift;
    assign q_next    = {div_q[62:0], rem_ge};

    always_ff @(posedge clk or negedge full_rs) begin
        if (!full_rs) begin
            div_q                <= '0;
            div_rem              <= '0;
            div_d                <= '0;
            div_iter             <= '0;
            no_packet_recieve    <= '0;
            averge_time_of_flies <= '0;
        end else begin
            case (state)
                RPT_LATCH: begin
                    div_q    <= lat_sum;
                    div_rem  <= '0;
                    div_d    <= pkt_cnt;
                    div_iter <= '0;
                    if (pkt_cnt == '0) begin
                        no_packet_recieve    <= '0;
                        averge_time_of_flies <= '0;
                    end
                end
                RPT_DIV: begin
                    div_q    <= q_next;
                    // Remainder stays below the 32-bit divisor.
                    div_rem  <= rem_next[31:0];
                    div_iter <= div_iter + 6'd1;
                    if (div_iter == 6'd63) begin
                        no_packet_recieve    <= div_d;
                        averge_time_of_flies <= (|q_next[63:32]) ? 32'hFFFF_FFFF
                                                                 : q_next[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ejection_sink.sv
// ---------------------------------------------------------------------------
// Directed testbench for pe_ejection_sink (default parameters). The bench
// keeps its own copy of the DUT cycle counter in cyc; flits are driven while
// cyc holds the named cycle number.
// ---------------------------------------------------------------------------
module tb_pe_ejection_sink;

    localparam logic [1:0] FT_BODY = 2'b00, FT_HEAD = 2'b01,
                           FT_TAIL = 2'b10, FT_HT   = 2'b11;
`ifdef PE_SINK_MAX_LAT_EN
    localparam bit max_en = 1'b1;
`else
    localparam bit max_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        full_rs = 1'b0;
    logic        flit_valid = 1'b0;
    logic [31:0] flit_in = '0;
    logic [1:0]  flit_type = '0;
    logic [1:0]  flit_vc = '0;
    logic [3:0]  credit_out;
    logic        stats_clr = 1'b0;
    logic        report_req = 1'b0;
    logic        report_busy, report_valid;
    logic [31:0] no_packet_recieve, averge_time_of_flies;
    logic [23:0] max_latency;
    logic        protocol_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pe_ejection_sink dut (
        .clk                 (clk),
        .full_rs             (full_rs),
        .flit_valid          (flit_valid),
        .flit_in             (flit_in),
        .flit_type           (flit_type),
        .flit_vc             (flit_vc),
        .credit_out          (credit_out),
        .stats_clr           (stats_clr),
        .report_req          (report_req),
        .report_busy         (report_busy),
        .report_valid        (report_valid),
        .no_packet_recieve   (no_packet_recieve),
        .averge_time_of_flies(averge_time_of_flies),
        .max_latency         (max_latency),
        .protocol_err        (protocol_err)
    );

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    // Present one flit during the current cycle; returns in the next cycle.
    task automatic send(input logic [1:0] vc, input logic [1:0] typ,
                        input logic [23:0] ts);
        flit_valid = 1'b1;
        flit_vc    = vc;
        flit_type  = typ;
        flit_in    = {8'hA5, ts};
        tick();
        flit_valid = 1'b0;
        flit_type  = FT_BODY;
        flit_in    = '0;
    endtask

    task automatic clr_pulse();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
    endtask

    task automatic chk_credit(input string name, input logic [3:0] exp);
        total++;
        if (credit_out !== exp) begin
            bad++;
            $display("FAIL %s credit_out got=%b exp=%b", name, credit_out, exp);
        end
    endtask

    task automatic chk_err(input string name, input logic exp);
        total++;
        if (protocol_err !== exp) begin
            bad++;
            $display("FAIL %s protocol_err got=%b exp=%b", name, protocol_err, exp);
        end
    endtask

    task automatic chk_max(input string name, input logic [23:0] exp);
        total++;
        if (max_latency !== exp) begin
            bad++;
            $display("FAIL %s max_latency got=%0h exp=%0h", name, max_latency, exp);
        end
    endtask

    // Request a report at the current cycle T and follow it cycle by cycle:
    // busy must hold for T+1..T+n and valid must pulse only at T+n. With
    // disturb set, a clear plus a redundant request arrive at T+10 and a new
    // counted packet at T+20; neither may change the result.
    task automatic run_report(input string name, input int n,
                              input logic [31:0] exp_cnt,
                              input logic [31:0] exp_avg, input bit disturb);
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        for (int i = 1; i <= n; i++) begin
            total++;
            if (report_busy !== 1'b1 || report_valid !== (i == n)) begin
                bad++;
                $display("FAIL %s handshake at T+%0d busy/valid got=%b%b exp=1%b",
                         name, i, report_busy, report_valid, (i == n));
            end
            if (disturb) begin
                if (i == 10) begin
                    stats_clr  = 1'b1;
                    report_req = 1'b1;
                end else if (i == 11) begin
                    stats_clr  = 1'b0;
                    report_req = 1'b0;
                end
                if (i == 20) begin
                    flit_valid = 1'b1;
                    flit_vc    = 2'd3;
                    flit_type  = FT_HT;
                    flit_in    = {8'h00, 24'(cyc - 500)};
                end else if (i == 21) begin
                    flit_valid = 1'b0;
                    flit_type  = FT_BODY;
                    flit_in    = '0;
                end
            end
            if (i < n) tick();
        end
        total++;
        if (no_packet_recieve !== exp_cnt) begin
            bad++;
            $display("FAIL %s count got=%0d exp=%0d", name, no_packet_recieve, exp_cnt);
        end
        total++;
        if (averge_time_of_flies !== exp_avg) begin
            bad++;
            $display("FAIL %s avg got=%0d exp=%0d", name, averge_time_of_flies, exp_avg);
        end
        tick();
        total++;
        if (report_busy !== 1'b0 || report_valid !== 1'b0 ||
            no_packet_recieve !== exp_cnt || averge_time_of_flies !== exp_avg) begin
            bad++;
            $display("FAIL %s after_done busy=%b valid=%b cnt=%0d avg=%0d exp 0 0 %0d %0d",
                     name, report_busy, report_valid, no_packet_recieve,
                     averge_time_of_flies, exp_cnt, exp_avg);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (credit_out !== '0 || report_busy !== 1'b0 || report_valid !== 1'b0 ||
            no_packet_recieve !== '0 || averge_time_of_flies !== '0 ||
            max_latency !== '0 || protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL %s outputs credit=%b busy=%b valid=%b cnt=%0d avg=%0d max=%0h err=%b exp all 0",
                     name, credit_out, report_busy, report_valid, no_packet_recieve,
                     averge_time_of_flies, max_latency, protocol_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        full_rs = 1'b1;
        cyc     = 0;
        tick();
        check_all_zero("post_reset");
    endtask

    // Completion at 1999 is not counted, completion at 2000 is.
    task automatic test_warmup();
        goto_cyc(1999);
        send(2'd0, FT_HT, 24'd1989);
        chk_credit("warmup_credit0", 4'b0001);
        send(2'd1, FT_HT, 24'd1990);
        chk_credit("warmup_credit1", 4'b0010);
        goto_cyc(2010);
        run_report("warmup", 66, 32'd1, 32'd10, 1'b0);
    endtask

    task automatic test_single();
        goto_cyc(2990);
        clr_pulse();
        goto_cyc(3000);
        send(2'd0, FT_HT, 24'd2995);
        chk_credit("single_credit", 4'b0001);
        goto_cyc(3005);
        run_report("single", 66, 32'd1, 32'd5, 1'b0);
    endtask

    task automatic test_interleave();
        goto_cyc(3080);
        clr_pulse();
        goto_cyc(3090);
        send(2'd2, FT_HEAD, 24'd3000);
        chk_credit("ilv_head_credit", 4'b0100);
        chk_err("ilv_head_ok", 1'b0);
        send(2'd1, FT_BODY, 24'd0);
        chk_credit("ilv_stray_credit", 4'b0010);
        chk_err("ilv_stray_err", 1'b1);
        goto_cyc(3100);
        send(2'd2, FT_TAIL, 24'd0);
        chk_credit("ilv_tail_credit", 4'b0100);
        goto_cyc(3105);
        run_report("interleave", 66, 32'd1, 32'd100, 1'b0);
        chk_err("ilv_sticky", 1'b1);
        clr_pulse();
        chk_err("ilv_cleared", 1'b0);
    endtask

    // Latencies 10, 20, 31: sum 61, average 20.
    task automatic test_back_to_back();
        goto_cyc(3190);
        clr_pulse();
        goto_cyc(3200);
        send(2'd0, FT_HT, 24'd3190);
        goto_cyc(3205);
        send(2'd3, FT_HEAD, 24'd3190);
        goto_cyc(3210);
        send(2'd3, FT_TAIL, 24'd0);
        goto_cyc(3220);
        send(2'd1, FT_HT, 24'd3189);
        goto_cyc(3230);
        chk_max("avg_max", max_en ? 24'd31 : 24'd0);
        run_report("average", 66, 32'd3, 32'd20, 1'b1);
    endtask

    task automatic test_zero_count();
        goto_cyc(3300);
        clr_pulse();
        goto_cyc(3310);
        stats_clr  = 1'b1;
        flit_valid = 1'b1;
        flit_vc    = 2'd0;
        flit_type  = FT_HT;
        flit_in    = {8'h00, 24'd3300};
        tick();
        stats_clr  = 1'b0;
        flit_valid = 1'b0;
        flit_type  = FT_BODY;
        flit_in    = '0;
        chk_max("zero_max", 24'd0);
        goto_cyc(3320);
        run_report("zero", 2, 32'd0, 32'd0, 1'b0);
    endtask

    // ts=0xFFFFF0 completed at cycle 3600 (0xE10): latency 0xE20 modulo 2^24.
    task automatic test_wrap();
        goto_cyc(3600);
        send(2'd2, FT_HT, 24'hFFFFF0);
        chk_max("wrap_max", max_en ? 24'h000E20 : 24'd0);
        goto_cyc(3610);
        run_report("wrap", 66, 32'd1, 32'h0000_0E20, 1'b0);
    endtask

    task automatic test_reset_mid();
        int seen;
        goto_cyc(3680);
        send(2'd1, FT_HEAD, 24'd100);
        goto_cyc(3690);
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        repeat (20) tick();
        #3;
        full_rs = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(posedge clk);
        @(posedge clk);
        #1;
        full_rs = 1'b1;
        cyc     = 0;
        send(2'd1, FT_BODY, 24'd0);
        chk_err("reset_vc_idle", 1'b1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (report_valid !== 1'b0 || report_busy !== 1'b0) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_no_report busy/valid cycles got=%0d exp=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_single();
        test_interleave();
        test_back_to_back();
        test_zero_count();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_ejection_sink.md
# pe_ejection_sink

Per-PE packet sink attached to the local ejection port of a router in `network`. Accepts flits under credit flow control and tracks wormhole packets independently per virtual channel. Computes each packet's network latency from the injection timestamp carried in its head flit. Accumulates post-warm-up statistics and, on request from `manager`, produces packet count and average latency through a sequential divider.

## Interface
Parameters:
- `no_vc`, 4, virtual channels on the ejection port; `vc_bits = (no_vc>1)?$clog2(no_vc):1`.
- `phit_size`, 32, flit width in bits (flit = one phit).
- `ts_width`, 24, timestamp field width; occupies flit bits `[ts_width-1:0]` of head flits.
- `warm_up_time`, 2000, packets whose tail arrives at cycle < this are not counted.

Ports:
- `clk` in 1: clock.
- `full_rs` in 1: asynchronous, active-low reset.
- `flit_valid` in 1: flit present this cycle.
- `flit_in` in phit_size: flit data.
- `flit_type` in 2: 00 body, 01 head, 10 tail, 11 head+tail (single-flit packet).
- `flit_vc` in vc_bits: VC of the flit.
- `credit_out` out no_vc: one-cycle credit pulse per consumed flit, bit = VC.
- `stats_clr` in 1: synchronous clear of statistics.
- `report_req` in 1: start average computation.
- `report_busy` out 1: divider running.
- `report_valid` out 1: one-cycle pulse, results valid.
- `no_packet_recieve` out 32: snapshot packet count.
- `averge_time_of_flies` out 32: snapshot average latency, cycles.
- `max_latency` out ts_width: largest counted latency (see Configuration).
- `protocol_err` out 1: sticky framing-error flag.

## Operation
- Free-running `cycle_cnt` (32 bit, wraps) starts at 0 after reset; timestamps compare against `cycle_cnt[ts_width-1:0]`.
- Sink always accepts: every valid flit is consumed the cycle it is presented.
- Per-VC state: IDLE / IN_PKT plus a stored `ts_width` head timestamp.
  - head in IDLE: store timestamp, -> IN_PKT.
  - body/tail in IN_PKT: tail -> IDLE and the packet completes.
  - head+tail in IDLE: completes immediately using its own timestamp.
  - Head or head+tail in IN_PKT: set `protocol_err`, restart the packet with the new timestamp.
  - Body or tail in IDLE: set `protocol_err`, drop the flit. Credit is still returned.
- Latency = `(cycle_cnt - ts) mod 2^ts_width`, taken at the completing flit's cycle.
- Counting: only when `cycle_cnt >= warm_up_time`.
  - `pkt_cnt` is 32 bit, saturating at 0xFFFFFFFF.
  - `lat_sum` is 64 bit, saturating.
- `stats_clr`: zeroes `pkt_cnt`, `lat_sum`, max-latency register and `protocol_err`. It does not touch per-VC state, `cycle_cnt` or report outputs.
- Report FSM states and transitions:
  - IDLE: on `report_req` -> LATCH.
  - LATCH: snapshot `pkt_cnt` and `lat_sum`. Count 0 -> DONE with avg 0; otherwise -> DIV.
  - DIV: 64-iteration restoring divide, `lat_sum / pkt_cnt`. Quotient ≥ 2^32 saturates to 0xFFFFFFFF.
  - DONE: drive outputs, pulse `report_valid`, -> IDLE.
- Result outputs hold their value until the next DONE.

## Timing
- Reset values:
  - all outputs 0;
  - `cycle_cnt` 0, all VCs IDLE, FSM IDLE;
  - counters, sum and max 0.
- `credit_out[flit_vc]` pulses in cycle T+1 for a flit accepted at T.
- Statistics update in cycle T+1 for a completing flit at T.
- `report_req` sampled at T:
  - LATCH at T+1;
  - count 0: `report_valid` at T+2;
  - otherwise DIV T+2..T+65, `report_valid` at T+66.
- `report_busy` is high from T+1 through the `report_valid` cycle.
- `report_req` while busy is ignored.
- Same-cycle events:
  - `stats_clr` with a completing packet: clear wins, that packet is not counted.
  - `stats_clr` or new packets during DIV: do not affect the in-flight result, which uses the snapshot.
  - `report_req` with a completing packet at T: the packet is included, since the snapshot is taken at T+1.
- Reset asserted mid-packet or mid-divide: everything returns to reset values asynchronously. No `report_valid` is produced.

## Configuration
- `PE_SINK_MAX_LAT_EN` defined:
  - track the maximum counted latency, updated with the same gating and clear as `pkt_cnt`;
  - `max_latency` is registered.
- Not defined: no max register is built; `max_latency` is tied to 0.

## Test plan
- Reset, then head+tail on VC0 with ts=2995 at cycle 3000 -> credit_out=0001 at 3001, pkt_cnt=1, lat_sum=5.
- Head on VC2 (ts=2900) at cycle 2990, body on VC1 at 2991, tail on VC2 at 3000 -> latency 100 counted; VC1 body sets `protocol_err`, flit dropped, credit_out[1] pulses.
- Packet completing at cycle 1999 -> not counted. Same packet pattern completing at 2000 -> counted.
- Counted latencies 10, 20, 31 then `report_req` at T -> `report_valid` at T+66, count=3, avg=20, `report_busy` high T+1..T+66.
- `report_req` with count 0 -> `report_valid` at T+2, avg=0. `stats_clr` plus tail in the same cycle -> count stays 0.
- ts=0xFFFFF0, tail at `cycle_cnt[23:0]`=0x000010 -> latency 0x20 (wrap). Max latency 0x20 with `PE_SINK_MAX_LAT_EN`, 0 without.
